// File: rtl/inst_cache.sv
`default_nettype none
// ============================================================================
// inst_cache : direct-mapped read-only instruction cache with line burst refill
// Optional feature macro: ICACHE_PERF_EN (hit/miss performance counters)
// Revision   : 1.0
// ============================================================================
module inst_cache #(
  parameter int LINE_WORDS = 4,
  parameter int NUM_LINES  = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc,
  input  logic        inst_req_valid,
  output logic        inst_req_ready,
  output logic [31:0] instruction,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] mem_araddr,
  output logic        mem_arvalid,
  input  logic        mem_arready,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rvalid,
  output logic        mem_rready,
`ifdef ICACHE_PERF_EN
  output logic [31:0] perf_hit_cnt,
  output logic [31:0] perf_miss_cnt,
`endif
  input  logic        mem_rlast
);
  localparam int OFF  = $clog2(LINE_WORDS);
  localparam int IDX  = $clog2(NUM_LINES);
  localparam int TAGW = 30 - OFF - IDX;
  localparam logic [OFF-1:0] C_LAST_BEAT = OFF'(LINE_WORDS - 1);

  typedef enum logic [4:0] {
    IDLE     = 5'b00001,
    LOOKUP   = 5'b00010,
    MISS_REQ = 5'b00100,
    REFILL   = 5'b01000,
    RESP     = 5'b10000
  } state_t;

  state_t               state_q;
  logic [31:0]          req_pc_q;
  logic [OFF-1:0]       cnt_q;
  logic [NUM_LINES-1:0] valid_q;
  logic [TAGW-1:0]      tag_q  [NUM_LINES];
  logic [31:0]          data_q [NUM_LINES][LINE_WORDS];

  logic                 inst_req_ready_q;
  logic                 inst_valid_q;
  logic                 mem_arvalid_q;
  logic                 mem_rready_q;
  logic [31:0]          mem_araddr_q;
  logic [31:0]          instruction_q;
`ifdef ICACHE_PERF_EN
  logic [31:0]          perf_hit_q;
  logic [31:0]          perf_miss_q;
`endif

  logic [OFF-1:0]       w_off;
  logic [IDX-1:0]       w_idx;
  logic [TAGW-1:0]      w_tag;
  logic                 w_hit;
  logic                 w_beat;
  logic                 w_last_beat;

  assign w_off       = req_pc_q[2+OFF-1:2];
  assign w_idx       = req_pc_q[2+OFF+IDX-1:2+OFF];
  assign w_tag       = req_pc_q[31:2+OFF+IDX];
  assign w_hit       = valid_q[w_idx] && (tag_q[w_idx] == w_tag);
  assign w_beat      = (state_q == REFILL) && mem_rvalid && mem_rready_q;
  assign w_last_beat = w_beat && (cnt_q == C_LAST_BEAT);

  // Payload arrays carry no reset; the valid bits alone qualify them.
  always_ff @(posedge clk) begin
    if (w_beat) begin
      data_q[w_idx][cnt_q] <= mem_rdata;
    end
    if (w_last_beat) begin
      tag_q[w_idx] <= w_tag;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      req_pc_q         <= '0;
      cnt_q            <= '0;
      valid_q          <= '0;
      inst_req_ready_q <= 1'b1;
      inst_valid_q     <= 1'b0;
      mem_arvalid_q    <= 1'b0;
      mem_rready_q     <= 1'b0;
      mem_araddr_q     <= '0;
      instruction_q    <= '0;
`ifdef ICACHE_PERF_EN
      perf_hit_q       <= '0;
      perf_miss_q      <= '0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (inst_req_valid && inst_req_ready_q) begin
            req_pc_q         <= pc;
            inst_req_ready_q <= 1'b0;
            state_q          <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (w_hit) begin
            instruction_q <= data_q[w_idx][w_off];
            inst_valid_q  <= 1'b1;
            state_q       <= RESP;
`ifdef ICACHE_PERF_EN
            perf_hit_q    <= perf_hit_q + 32'd1;
`endif
          end else begin
            mem_araddr_q  <= {req_pc_q[31:2+OFF], {(2+OFF){1'b0}}};
            mem_arvalid_q <= 1'b1;
            state_q       <= MISS_REQ;
`ifdef ICACHE_PERF_EN
            perf_miss_q   <= perf_miss_q + 32'd1;
`endif
          end
        end
        MISS_REQ: begin
          if (mem_arready) begin
            mem_arvalid_q  <= 1'b0;
            mem_rready_q   <= 1'b1;
            cnt_q          <= '0;
            valid_q[w_idx] <= 1'b0;
            state_q        <= REFILL;
          end
        end
        REFILL: begin
          if (w_beat) begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == C_LAST_BEAT) begin
              valid_q[w_idx] <= 1'b1;
              mem_rready_q   <= 1'b0;
              inst_valid_q   <= 1'b1;
              // The final beat is written this same edge, so forward it directly.
              instruction_q  <= (w_off == cnt_q) ? mem_rdata : data_q[w_idx][w_off];
              state_q        <= RESP;
            end
          end
        end
        RESP: begin
          if (inst_ready) begin
            inst_valid_q     <= 1'b0;
            inst_req_ready_q <= 1'b1;
            state_q          <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign inst_req_ready = inst_req_ready_q;
  assign inst_valid     = inst_valid_q;
  assign instruction    = instruction_q;
  assign mem_arvalid    = mem_arvalid_q;
  assign mem_araddr     = mem_araddr_q;
  assign mem_rready     = mem_rready_q;
`ifdef ICACHE_PERF_EN
  assign perf_hit_cnt   = perf_hit_q;
  assign perf_miss_cnt  = perf_miss_q;
`endif

  // The beat counter alone terminates a refill; rlast and the byte offset are don't-care.
  logic unused_ok;
  assign unused_ok = ^{mem_rlast, req_pc_q[1:0]};

endmodule
`default_nettype wire

// File: tb/tb_inst_cache.sv
`default_nettype none
// ============================================================================
// tb_inst_cache : scoreboard bench for inst_cache with a burst memory responder
// Revision      : 1.0
// ============================================================================
module tb_inst_cache;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] pc = '0;
  logic        inst_req_valid = 1'b0;
  logic        inst_req_ready;
  logic [31:0] instruction;
  logic        inst_valid;
  logic        inst_ready = 1'b1;
  logic [31:0] mem_araddr;
  logic        mem_arvalid;
  logic        mem_arready = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        mem_rvalid = 1'b0;
  logic        mem_rready;
  logic        mem_rlast = 1'b0;
`ifdef ICACHE_PERF_EN
  logic [31:0] perf_hit_cnt;
  logic [31:0] perf_miss_cnt;
`endif

  inst_cache #(.LINE_WORDS(4), .NUM_LINES(8)) dut (
    .clk(clk), .rst_n(rst_n), .pc(pc),
    .inst_req_valid(inst_req_valid), .inst_req_ready(inst_req_ready),
    .instruction(instruction), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .mem_araddr(mem_araddr), .mem_arvalid(mem_arvalid), .mem_arready(mem_arready),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid), .mem_rready(mem_rready),
`ifdef ICACHE_PERF_EN
    .perf_hit_cnt(perf_hit_cnt), .perf_miss_cnt(perf_miss_cnt),
`endif
    .mem_rlast(mem_rlast)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [31:0] inst; int lat; } exp_t;
  exp_t        exp_inst_q[$];
  logic [31:0] exp_ar_q[$];

  int ar_delay = 0;
  int beat_gap = 0;
  int beats_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] memval(input logic [31:0] a);
    if (a < 32'h10) return 32'h11 * (32'(a[3:2]) + 32'd1);
    return 32'hA000_0000 | a;
  endfunction

  // Monitor: pops expected responses / burst addresses as the DUT presents them.
  int          hs_cyc = 0;
  bit          iv_seen = 0, ar_seen = 0;
  logic [31:0] iv_held, ar_held;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      iv_seen = 0;
      ar_seen = 0;
    end else begin
      if (inst_req_valid && inst_req_ready) hs_cyc = cyc;
      if (inst_valid) begin
        if (!iv_seen) begin
          iv_seen = 1;
          iv_held = instruction;
          if (exp_inst_q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_inst: got %h expected none", instruction);
          end else begin
            e = exp_inst_q.pop_front();
            chk("instruction", instruction, e.inst);
            if (e.lat >= 0) chk("hit_latency", 32'(cyc - hs_cyc), 32'(e.lat));
          end
        end else begin
          chk("instruction_stable", instruction, iv_held);
        end
        if (inst_ready) iv_seen = 0;
      end
      if (mem_arvalid) begin
        if (!ar_seen) begin
          ar_seen = 1;
          ar_held = mem_araddr;
          if (exp_ar_q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_ar: got %h expected none", mem_araddr);
          end else begin
            chk("araddr", mem_araddr, exp_ar_q.pop_front());
            chk("ar_latency", 32'(cyc - hs_cyc), 32'd2);
          end
        end else begin
          chk("araddr_stable", mem_araddr, ar_held);
        end
        if (mem_arready) ar_seen = 0;
      end
      if (mem_rvalid && mem_rready) beats_seen++;
    end
  end

  // Memory responder: handshakes sampled at negedge, drives updated after posedge.
  initial begin : mem_model
    int          wait_c, beat, gap;
    bit          in_burst, ar_hs, r_hs, arv;
    logic [31:0] base, addr_s;
    in_burst = 0; wait_c = 0; beat = 0; gap = 0; base = '0;
    forever begin
      @(negedge clk);
      ar_hs  = mem_arvalid && mem_arready;
      r_hs   = mem_rvalid && mem_rready;
      arv    = mem_arvalid;
      addr_s = mem_araddr;
      @(posedge clk);
      #1;
      if (!rst_n) begin
        in_burst = 0; wait_c = 0;
        mem_arready = 1'b0; mem_rvalid = 1'b0; mem_rlast = 1'b0;
      end else begin
        if (ar_hs) begin
          mem_arready = 1'b0;
          in_burst = 1; base = addr_s; beat = 0; gap = beat_gap; wait_c = 0;
        end else if (!in_burst && arv) begin
          if (wait_c >= ar_delay) mem_arready = 1'b1;
          else wait_c++;
        end
        if (in_burst) begin
          if (r_hs) begin
            beat++;
            mem_rvalid = 1'b0;
            mem_rlast = 1'b0;
            gap = beat_gap;
            if (beat == 4) in_burst = 0;
          end
          if (in_burst && !mem_rvalid) begin
            if (gap > 0) gap--;
            else begin
              mem_rvalid = 1'b1;
              mem_rdata  = memval(base + 32'(beat * 4));
              mem_rlast  = (beat == 3);
            end
          end
        end
      end
    end
  end

  task automatic issue(input logic [31:0] a);
    int n;
    n = 0;
    @(posedge clk);
    #1;
    pc = a;
    inst_req_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (inst_req_ready) break;
      n++;
      if (n > 300) begin
        total++; bad++;
        $display("FAIL req_timeout: pc %h not accepted", a);
        break;
      end
    end
    @(posedge clk);
    #1;
    inst_req_valid = 1'b0;
    pc = 32'hDEAD_BEEF;
  endtask

  task automatic req(input logic [31:0] a, input logic [31:0] inst, input int lat,
                     input bit miss, input logic [31:0] ar);
    exp_t e;
    e.inst = inst;
    e.lat  = lat;
    exp_inst_q.push_back(e);
    if (miss) exp_ar_q.push_back(ar);
    issue(a);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_inst_q.size() != 0 || exp_ar_q.size() != 0 || inst_valid || !inst_req_ready) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) begin
      total++; bad++;
      $display("FAIL drain_timeout: pending inst=%0d ar=%0d", exp_inst_q.size(), exp_ar_q.size());
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, 32'(inst_req_ready), 32'd1);
    chk({tag, "_inst_valid"}, 32'(inst_valid), 32'd0);
    chk({tag, "_arvalid"}, 32'(mem_arvalid), 32'd0);
    chk({tag, "_rready"}, 32'(mem_rready), 32'd0);
    chk({tag, "_araddr"}, mem_araddr, 32'd0);
    chk({tag, "_instruction"}, instruction, 32'd0);
`ifdef ICACHE_PERF_EN
    chk({tag, "_perf_hit"}, perf_hit_cnt, 32'd0);
    chk({tag, "_perf_miss"}, perf_miss_cnt, 32'd0);
`endif
  endtask

  initial begin : stimulus
    int b0, n;
    repeat (2) @(negedge clk);
    check_reset_outputs("por");
    rst_n = 1'b1;

    // Cold miss then hits within the same line.
    req(32'h0, 32'h11, -1, 1, 32'h0);
    req(32'h4, 32'h22, 2, 0, 32'h0);
    req(32'h8, 32'h33, 2, 0, 32'h0);
    wait_drain();
`ifdef ICACHE_PERF_EN
    chk("perf_miss", perf_miss_cnt, 32'd1);
    chk("perf_hit", perf_hit_cnt, 32'd2);
`endif
    // Byte offset bits are ignored.
    req(32'h6, 32'h22, 2, 0, 32'h0);
    req(32'hC, 32'h44, 2, 0, 32'h0);

    // Conflict eviction on index 0.
    req(32'h80, 32'hA000_0080, -1, 1, 32'h80);
    req(32'h0, 32'h11, -1, 1, 32'h0);
    wait_drain();

    // Backpressure on every channel.
    ar_delay = 5;
    beat_gap = 2;
    inst_ready = 1'b0;
    req(32'h88, 32'hA000_0088, -1, 1, 32'h80);
    n = 0;
    while (!inst_valid && n < 300) begin @(negedge clk); n++; end
    if (n >= 300) begin
      total++; bad++;
      $display("FAIL resp_timeout: inst_valid %0d expected 1", inst_valid);
    end
    repeat (3) @(posedge clk);
    #1;
    inst_ready = 1'b1;
    wait_drain();
    ar_delay = 0;
    beat_gap = 0;
    req(32'h80, 32'hA000_0080, 2, 0, 32'h0);
    req(32'h8C, 32'hA000_008C, 2, 0, 32'h0);
    wait_drain();

    // Reset in the middle of a refill.
    b0 = beats_seen;
    exp_ar_q.push_back(32'h100);
    issue(32'h100);
    n = 0;
    while (beats_seen < b0 + 2 && n < 300) begin @(posedge clk); #2; n++; end
    if (n >= 300) begin
      total++; bad++;
      $display("FAIL beat_timeout: beats %0d expected %0d", beats_seen - b0, 2);
    end
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("midrst");
    @(negedge clk);
    check_reset_outputs("midrst2");
    rst_n = 1'b1;
    req(32'h0, 32'h11, -1, 1, 32'h0);
    req(32'h4, 32'h22, 2, 0, 32'h0);
    wait_drain();
`ifdef ICACHE_PERF_EN
    chk("perf_miss_after_rst", perf_miss_cnt, 32'd1);
    chk("perf_hit_after_rst", perf_hit_cnt, 32'd1);
`endif

    chk("pending_inst", 32'(exp_inst_q.size()), 32'd0);
    chk("pending_ar", 32'(exp_ar_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: time %0t exceeded limit", $time);
    $fatal(1, "watchdog expired");
  end
endmodule
`default_nettype wire
